// File: rtl/prefetch_unit.sv
// prefetch_unit -- bus-control / opcode prefetch queue for the V30MZ core.
//
// Fetches code bytes from {PS,0000}+PFP over the 16-bit bus into a byte FIFO.
// The FIFO head is exposed as a PEEK-byte window so the decoder can consume
// opcode, modrm, displacement and immediate bytes in a single cycle.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   flush           discard queue and restart at flush_ps:flush_pc
//   flush_ps/pc     new program segment / fetch offset
//   pop_count       bytes consumed by the decoder this cycle
//   bus_ready_n     low = bus_data valid this cycle
//   bus_data        read data, even-address byte on [7:0]
//   bus_addr        fetch address (registered, stable for the whole bus cycle)
//   bus_status      4'h9 code fetch, 4'hF idle
//   peek_data       byte i = queue[head+i], zero beyond the held level
//   level           bytes held
//   pfp             next fetch offset
//   underflow       sticky flag: decoder asked for more bytes than were held
module prefetch_unit #(
    parameter int          DEPTH    = 8,
    parameter int          PEEK     = 4,
    parameter logic [15:0] RESET_PS = 16'hFFFF,
    parameter logic [15:0] RESET_PC = 16'h0000,
    localparam int         PCW      = $clog2(PEEK + 1),
    localparam int         LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [15:0]       flush_ps,
    input  logic [15:0]       flush_pc,
    input  logic [PCW-1:0]    pop_count,
    input  logic              bus_ready_n,
    input  logic [15:0]       bus_data,
    output logic [19:0]       bus_addr,
    output logic [3:0]        bus_status,
    output logic [8*PEEK-1:0] peek_data,
    output logic [LW-1:0]     level,
    output logic [15:0]       pfp,
    output logic              underflow
);

    localparam int          AW          = $clog2(DEPTH);
    localparam logic [3:0]  ST_FETCH    = 4'h9;
    localparam logic [3:0]  ST_IDLE     = 4'hF;
    localparam logic [19:0] RESET_ADDR  = {RESET_PS, 4'b0} + {4'b0, RESET_PC};

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t         state_q, state_d;
    logic [15:0]    ps_q, ps_d;
    logic [15:0]    pfp_q, pfp_d;
    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [LW-1:0]  level_q, level_d;
    logic           underflow_q, underflow_d;
    logic [3:0]     bus_status_q, bus_status_d;
    logic [19:0]    bus_addr_q, bus_addr_d;
    logic [7:0]     mem_q [DEPTH];
    logic [7:0]     mem_d [DEPTH];

    logic [LW-1:0]  need, space, pop_req, pop_eff, pushed;
    logic [19:0]    fetch_addr;
    logic           bus_done, push, over_pop;

    // Odd offsets take one byte from the high lane, after which fetches align.
    assign need       = pfp_q[0] ? LW'(1) : LW'(2);
    // Space is judged on the registered level, before this cycle's pop.
    assign space      = LW'(DEPTH) - level_q;
    assign fetch_addr = {ps_q, 4'b0} + {4'b0, pfp_q};
    assign bus_done   = !bus_ready_n;

    // ---------------- FSM: state register ----------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: each always_comb assigns its outputs a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!flush && space >= need) state_d = S_FETCH;
            // A flush that coincides with the ready beat has nothing left to drain.
            S_FETCH: if (bus_done)                state_d = S_IDLE;
                     else if (flush)              state_d = S_DRAIN;
            S_DRAIN: if (bus_done)                state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered bus controls) ----------------
    always_comb begin
        bus_status_d = bus_status_q;
        bus_addr_d   = bus_addr_q;
        if (state_q == S_IDLE && state_d == S_FETCH) begin
            bus_status_d = ST_FETCH;
            bus_addr_d   = fetch_addr;
        end else if (state_q != S_IDLE && state_d == S_IDLE) begin
            bus_status_d = ST_IDLE;
        end
    end

    // ---------------- queue datapath ----------------
    always_comb begin
        push        = (state_q == S_FETCH) && bus_done && !flush;
        pop_req     = LW'(pop_count);
        over_pop    = pop_req > level_q;
        pop_eff     = over_pop ? level_q : pop_req;
        pushed      = push ? need : '0;

        mem_d       = mem_q;
        ps_d        = ps_q;
        pfp_d       = pfp_q;
        head_d      = head_q + AW'(pop_eff);
        tail_d      = tail_q + AW'(pushed);
        level_d     = level_q - pop_eff + pushed;
        underflow_d = underflow_q | over_pop;

        if (push) begin
            if (pfp_q[0]) begin
                mem_d[tail_q] = bus_data[15:8];
            end else begin
                mem_d[tail_q]          = bus_data[7:0];
                mem_d[tail_q + AW'(1)] = bus_data[15:8];
            end
            pfp_d = pfp_q + 16'(need);  // wraps within the segment, no PS carry
        end

        // Flush overrides push and pop; the decoder's pop is meaningless here.
        if (flush) begin
            ps_d        = flush_ps;
            pfp_d       = flush_pc;
            head_d      = tail_q;
            tail_d      = tail_q;
            level_d     = '0;
            underflow_d = underflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps_q         <= RESET_PS;
            pfp_q        <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            level_q      <= '0;
            underflow_q  <= 1'b0;
            bus_status_q <= ST_IDLE;
            bus_addr_q   <= RESET_ADDR;
        end else begin
            ps_q         <= ps_d;
            pfp_q        <= pfp_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            level_q      <= level_d;
            underflow_q  <= underflow_d;
            bus_status_q <= bus_status_d;
            bus_addr_q   <= bus_addr_d;
        end
    end

    // NOTE: queue storage has no reset; level/head/tail alone define which
    // bytes are valid, and peek_data masks everything beyond level.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Peek window: combinational from registered state, zero beyond level.
    always_comb begin
        peek_data = '0;
        for (int i = 0; i < PEEK; i++) begin
            if (LW'(i) < level_q) peek_data[8*i +: 8] = mem_q[head_q + AW'(i)];
        end
    end

    assign bus_addr   = bus_addr_q;
    assign bus_status = bus_status_q;
    assign level      = level_q;
    assign pfp        = pfp_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed testbench for prefetch_unit. A behavioural memory answers every
// bus cycle; expected bytes are queued when a beat is granted and compared
// against the peek window when the decoder side consumes them.
module tb_prefetch_unit;

    localparam int PCW = 3;
    localparam int LW  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [15:0] flush_ps;
    logic [15:0] flush_pc;
    logic [PCW-1:0] pop_count;
    logic        bus_ready_n;
    logic [15:0] bus_data;
    logic [19:0] bus_addr;
    logic [3:0]  bus_status;
    logic [31:0] peek_data;
    logic [LW-1:0] level;
    logic [15:0] pfp;
    logic        underflow;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [7:0]  sb [$];
    logic [15:0] m_ps;
    logic [15:0] m_pfp;

    prefetch_unit #(
        .DEPTH(8), .PEEK(4), .RESET_PS(16'hFFFF), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .flush_ps(flush_ps),
        .flush_pc(flush_pc), .pop_count(pop_count), .bus_ready_n(bus_ready_n),
        .bus_data(bus_data), .bus_addr(bus_addr), .bus_status(bus_status),
        .peek_data(peek_data), .level(level), .pfp(pfp), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Memory contents: a byte value derived from its 20-bit address.
    function automatic logic [7:0] mbyte(input logic [19:0] a);
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[19:16]} ^ 8'hA5;
    endfunction

    assign bus_data = {mbyte({bus_addr[19:1], 1'b1}), mbyte({bus_addr[19:1], 1'b0})};

    function automatic logic [19:0] model_addr();
        return {m_ps, 4'b0} + {4'b0, m_pfp};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one bus cycle: wait for it, hold `waits` wait states, then grant,
    // optionally popping pop_n bytes in the same cycle.
    task automatic bus_beat(input int waits, input int pop_n);
        int n;
        logic [19:0] a;
        n = 0;
        while (bus_status !== 4'h9 && n < 16) begin
            tick();
            n++;
        end
        a = model_addr();
        check("bus_status_fetch", 32'(bus_status), 32'h9);
        check("bus_addr", 32'(bus_addr), 32'(a));
        for (int i = 0; i < waits; i++) begin
            tick();
            check("bus_addr_hold", 32'(bus_addr), 32'(a));
        end
        for (int i = 0; i < pop_n; i++) begin
            check("peek_pop_beat", 32'(peek_data[8*i +: 8]), 32'(sb.pop_front()));
        end
        if (m_pfp[0]) begin
            sb.push_back(mbyte(a));
        end else begin
            sb.push_back(mbyte(a));
            sb.push_back(mbyte(a + 20'd1));
        end
        bus_ready_n = 1'b0;
        pop_count   = PCW'(pop_n);
        tick();
        bus_ready_n = 1'b1;
        pop_count   = '0;
        m_pfp = m_pfp + (m_pfp[0] ? 16'd1 : 16'd2);
        check("bus_status_idle", 32'(bus_status), 32'hF);
        check("level_after_beat", 32'(level), 32'(sb.size()));
        check("pfp_after_beat", 32'(pfp), 32'(m_pfp));
    endtask

    task automatic pop_check(input int n);
        check("level_before_pop", 32'(level), 32'(sb.size()));
        for (int i = 0; i < n; i++) begin
            check("peek_byte", 32'(peek_data[8*i +: 8]), 32'(sb.pop_front()));
        end
        pop_count = PCW'(n);
        tick();
        pop_count = '0;
        check("level_after_pop", 32'(level), 32'(sb.size()));
    endtask

    // Flush, then complete the abandoned bus cycle if one was in flight.
    task automatic do_flush(input logic [15:0] ps, input logic [15:0] pc);
        flush    = 1'b1;
        flush_ps = ps;
        flush_pc = pc;
        tick();
        flush = 1'b0;
        sb.delete();
        m_ps  = ps;
        m_pfp = pc;
        check("flush_level", 32'(level), 32'h0);
        check("flush_pfp", 32'(pfp), 32'(pc));
        if (bus_status === 4'h9) begin
            bus_ready_n = 1'b0;
            tick();
            bus_ready_n = 1'b1;
            check("flush_drain_idle", 32'(bus_status), 32'hF);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset       = 1'b1;
        flush       = 1'b0;
        flush_ps    = '0;
        flush_pc    = '0;
        pop_count   = '0;
        bus_ready_n = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_level", 32'(level), 32'h0);
        check("rst_status", 32'(bus_status), 32'hF);
        check("rst_addr", 32'(bus_addr), 32'hFFFF0);
        check("rst_pfp", 32'(pfp), 32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_peek", peek_data, 32'h0);
        m_ps  = 16'hFFFF;
        m_pfp = 16'h0000;
        reset = 1'b0;

        // 1: fill to capacity, bus goes quiet when full
        for (int i = 0; i < 4; i++) bus_beat(0, 0);
        check("full_level", 32'(level), 32'h8);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_status_idle", 32'(bus_status), 32'hF);
        end
        pop_check(4);

        // 2: odd-address branch, single byte then aligned word
        do_flush(16'h1000, 16'h0003);
        check("flush_peek_zero", peek_data, 32'h0);
        bus_beat(0, 0);
        check("odd_level1", 32'(level), 32'h1);
        bus_beat(0, 0);
        check("odd_level3", 32'(level), 32'h3);
        pop_check(3);

        // 3: flush during a stretched bus cycle -> drain, data discarded
        n = 0;
        while (bus_status !== 4'h9 && n < 16) begin
            tick();
            n++;
        end
        check("drain_fetch_started", 32'(bus_status), 32'h9);
        tick();
        tick();
        check("drain_addr_before", 32'(bus_addr), 32'(model_addr()));
        flush    = 1'b1;
        flush_ps = 16'h3000;
        flush_pc = 16'h0010;
        tick();
        flush = 1'b0;
        check("drain_status_held", 32'(bus_status), 32'h9);
        check("drain_level0", 32'(level), 32'h0);
        tick();
        check("drain_still_waiting", 32'(bus_status), 32'h9);
        bus_ready_n = 1'b0;
        tick();
        bus_ready_n = 1'b1;
        check("drain_done_idle", 32'(bus_status), 32'hF);
        check("drain_discarded", 32'(level), 32'h0);
        sb.delete();
        m_ps  = 16'h3000;
        m_pfp = 16'h0010;
        bus_beat(2, 0);
        pop_check(2);

        // 4: PFP wraps within the segment
        do_flush(16'h2000, 16'hFFFE);
        bus_beat(0, 0);
        check("wrap_pfp0", 32'(pfp), 32'h0);
        bus_beat(0, 0);
        check("wrap_level4", 32'(level), 32'h4);

        // 5: over-pop sets sticky underflow; push+pop in one cycle
        pop_check(2);
        check("uf_peek0", 32'(peek_data[7:0]), 32'(sb.pop_front()));
        check("uf_peek1", 32'(peek_data[15:8]), 32'(sb.pop_front()));
        pop_count = 3'd3;
        tick();
        pop_count = '0;
        check("uf_level0", 32'(level), 32'h0);
        check("uf_set", 32'(underflow), 32'h1);
        tick();
        check("uf_sticky", 32'(underflow), 32'h1);
        bus_beat(0, 0);
        do_flush(16'h2000, 16'h0101);
        check("uf_sticky_flush", 32'(underflow), 32'h1);
        bus_beat(0, 0);
        bus_beat(0, 0);
        bus_beat(0, 0);
        check("pp_level5", 32'(level), 32'h5);
        bus_beat(0, 2);
        check("pp_level_still5", 32'(level), 32'h5);
        pop_check(4);

        // 6: reset in the middle of a bus cycle
        n = 0;
        while (bus_status !== 4'h9 && n < 16) begin
            tick();
            n++;
        end
        check("rst2_fetch_started", 32'(bus_status), 32'h9);
        tick();
        reset = 1'b1;
        tick();
        check("rst2_status", 32'(bus_status), 32'hF);
        check("rst2_level", 32'(level), 32'h0);
        check("rst2_addr", 32'(bus_addr), 32'hFFFF0);
        check("rst2_underflow", 32'(underflow), 32'h0);
        bus_ready_n = 1'b0;
        reset       = 1'b0;
        tick();
        check("late_ready_level", 32'(level), 32'h0);
        check("late_ready_new_fetch", 32'(bus_status), 32'h9);
        check("late_ready_addr", 32'(bus_addr), 32'hFFFF0);
        bus_ready_n = 1'b1;
        tick();
        check("late_ready_still0", 32'(level), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
